// File: rtl/gb_frame_scaler_if.sv
// Bus bundle for gb_frame_scaler: source pixel capture, palette writes,
// output raster position in, and colour / frame status out.
// master: video core / HDMI timing side. slave: the scaler.
interface gb_frame_scaler_if #(
    parameter int PIX_BITS = 2
);
    logic                src_vs;
    logic                src_valid;
    logic [PIX_BITS-1:0] src_pixel;
    logic [10:0]         cx;
    logic [9:0]          cy;
    logic                pal_we;
    logic [PIX_BITS-1:0] pal_addr;
    logic [23:0]         pal_data;
    logic [23:0]         rgb;
    logic                frame_swap;
    logic                frame_drop;

    modport master (
        output src_vs, src_valid, src_pixel,
        output cx, cy,
        output pal_we, pal_addr, pal_data,
        input  rgb, frame_swap, frame_drop
    );

    modport slave (
        input  src_vs, src_valid, src_pixel,
        input  cx, cy,
        input  pal_we, pal_addr, pal_data,
        output rgb, frame_swap, frame_drop
    );
endinterface

// File: rtl/gb_frame_scaler.sv
// Double-buffered LCD frame store with integer up-scaling and palette lookup.
// Ports: clk, resetn (sync, active low), bus (gb_frame_scaler_if.slave).
module gb_frame_scaler #(
    parameter int          SRC_W      = 160,
    parameter int          SRC_H      = 144,
    parameter int          PIX_BITS   = 2,
    parameter int          SCALE_LOG2 = 2,
    parameter int          X_OFF      = 320,
    parameter int          Y_OFF      = 72,
    parameter logic [23:0] BORDER_RGB = 24'h0
) (
    input  logic              clk,
    input  logic              resetn,
    gb_frame_scaler_if.slave  bus
);
    localparam int NPIX  = SRC_W * SRC_H;
    localparam int AW    = $clog2(NPIX);
    localparam int CW    = $clog2(NPIX + 1);
    localparam int PAL_N = 2 ** PIX_BITS;
    localparam int MEM_D = 2 ** (AW + 1);

    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
    localparam logic [11:0]   X_LIM  = 12'(SRC_W << SCALE_LOG2);
    localparam logic [10:0]   Y_LIM  = 11'(SRC_H << SCALE_LOG2);

    logic [PIX_BITS-1:0] r_mem [0:MEM_D-1];
    logic [23:0]         r_pal [0:PAL_N-1];

    logic [CW-1:0]       r_wr_cnt;
    logic                r_long;
    logic                r_vs_d;
    logic                r_disp_bank;
    logic                r_swap;
    logic                r_drop;

    logic                r_inwin0;
    logic                r_inwin1;
    logic [AW-1:0]       r_addr;
    logic [PIX_BITS-1:0] r_pix;
    logic [23:0]         r_rgb;

    logic                w_vs_rise;
    logic                w_full;
    logic                w_do_swap;
    logic [CW-1:0]       w_cnt_base;
    logic                w_long_base;
    logic                w_wr_bank;
    logic                w_room;
    logic                w_we;
    logic [AW:0]         w_wr_addr;
    logic [10:0]         w_dx;
    logic [9:0]          w_dy;
    logic [AW-1:0]       w_rd_addr;

    // A vs edge closes the current frame before this cycle's pixel is
    // considered, so a coincident pixel starts the next frame at 0.
    assign w_vs_rise   = bus.src_vs & ~r_vs_d;
    assign w_full      = (r_wr_cnt == NPIX_C) & ~r_long;
    assign w_do_swap   = w_vs_rise & w_full;
    assign w_cnt_base  = w_vs_rise ? '0 : r_wr_cnt;
    assign w_long_base = w_vs_rise ? 1'b0 : r_long;

    // After a swap the old display bank becomes the write bank.
    assign w_wr_bank = w_do_swap ? r_disp_bank : ~r_disp_bank;
    assign w_room    = w_cnt_base < NPIX_C;
    assign w_we      = resetn & bus.src_valid & w_room;
    assign w_wr_addr = {w_wr_bank, w_cnt_base[AW-1:0]};

    // Unsigned wrap puts positions left of / above the window out of range.
    assign w_dx      = bus.cx - 11'(X_OFF);
    assign w_dy      = bus.cy - 10'(Y_OFF);
    assign w_rd_addr = AW'((32'(w_dy) >> SCALE_LOG2) * 32'(SRC_W)
                         + (32'(w_dx) >> SCALE_LOG2));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_cnt    <= '0;
            r_long      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_disp_bank <= 1'b0;
            r_swap      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_vs_d <= bus.src_vs;
            r_swap <= w_do_swap;
            if (w_do_swap) begin
                r_disp_bank <= ~r_disp_bank;
            end
            if (w_vs_rise & ~w_full) begin
                r_drop <= 1'b1;
            end
            r_wr_cnt <= w_we ? w_cnt_base + CW'(1) : w_cnt_base;
            r_long   <= w_long_base | (bus.src_valid & ~w_room);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wr_addr] <= bus.src_pixel;
        end
        r_pix <= r_mem[{r_disp_bank, r_addr}];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_inwin0 <= 1'b0;
            r_inwin1 <= 1'b0;
            r_addr   <= '0;
            r_rgb    <= 24'h0;
        end else begin
            r_inwin0 <= ({1'b0, w_dx} < X_LIM) && ({1'b0, w_dy} < Y_LIM);
            r_addr   <= w_rd_addr;
            r_inwin1 <= r_inwin0;
            r_rgb    <= r_inwin1 ? r_pal[r_pix] : BORDER_RGB;
        end
    end

    // Reset palette is a linear grey ramp.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_pal[i] <= {3{8'(i * 255 / (PAL_N - 1))}};
            end
        end else if (bus.pal_we) begin
            r_pal[bus.pal_addr] <= bus.pal_data;
        end
    end

    assign bus.rgb        = r_rgb;
    assign bus.frame_swap = r_swap;
    assign bus.frame_drop = r_drop;
endmodule
